jpeg_bitpack: RTL and testbench

- Entropy-coded segment packer for the JPEG encoder path. It is the transmit-side counterpart of the decoder's input register/unstuffing stage.
- Accepts variable-length Huffman code words and packs them MSB-first into bytes. Inserts 0x00 after every 0xFF data byte, which is JPEG byte stuffing.
- On flush, pads the last partial byte with 1s and appends the EOI marker 0xFFD9.
- Emits 32-bit words in stream order, first byte in [7:0], so the output feeds the decoder input bus directly.

---
 rtl/jpeg_enc_pkg.sv | 20 ++
 rtl/jpeg_bitpack_word.sv | 79 +++++++
 rtl/jpeg_bitpack.sv | 146 ++++++++++++++
 tb/tb_jpeg_bitpack.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared constants and state encoding for the JPEG encoder byte path.
package jpeg_enc_pkg;

    localparam int MAXW = 32;
    localparam int ACCW = 64;

    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] EOI_CODE      = 8'hD9;
    localparam logic [7:0] STUFF_BYTE    = 8'h00;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_PAD,
        ST_MRK_FF,
        ST_MRK_D9,
        ST_DRAIN,
        ST_DONE
    } bp_state_t;

endpackage

// File: rtl/jpeg_bitpack_word.sv
// Byte-to-word assembler plus registered output with Last/Bytes; one byte/cycle.
// Full word leaves when the output register is free; otherwise byte_rdy_o drops.
module jpeg_bitpack_word (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        byte_rdy_o,
    input  logic        drain_i,
    output logic        drain_done_o,
    output logic [31:0] dout_o,
    output logic        dout_vld_o,
    output logic        dout_last_o,
    output logic [2:0]  dout_bytes_o,
    input  logic        dout_rd_i
);
    logic [31:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] dout_q, dout_d;
    logic        vld_q, vld_d;
    logic        last_q, last_d;
    logic [2:0]  bytes_q, bytes_d;
    logic        out_free, xfer_full, xfer_last;

    assign out_free     = !vld_q | dout_rd_i;
    assign xfer_full    = (cnt_q == 3'd4) & out_free & !drain_i;
    assign xfer_last    = drain_i & out_free & (cnt_q != 3'd0);
    // A full word leaving frees slot 0 in the same cycle.
    assign byte_rdy_o   = (cnt_q < 3'd4) | xfer_full;
    assign drain_done_o = xfer_last;

    assign dout_o       = dout_q;
    assign dout_vld_o   = vld_q;
    assign dout_last_o  = last_q;
    assign dout_bytes_o = bytes_q;

    always_comb begin
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        vld_d   = vld_q;
        last_d  = last_q;
        bytes_d = bytes_q;
        if (xfer_full || xfer_last) begin
            dout_d  = buf_q;
            vld_d   = 1'b1;
            last_d  = xfer_last;
            bytes_d = cnt_q;
            buf_d   = '0;
            cnt_d   = 3'd0;
        end else if (dout_rd_i) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
        if (byte_vld_i && byte_rdy_o) begin
            buf_d[{cnt_d[1:0], 3'b000} +: 8] = byte_dat_i;
            cnt_d = cnt_d + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            bytes_q <= '0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            bytes_q <= bytes_d;
        end
    end

endmodule

// File: rtl/jpeg_bitpack.sv
// JPEG entropy-segment packer: MSB-first bit packing, 0xFF stuffing, 1-padding, EOI.
// Codes accepted while the accumulator has MAXW bits of room; stalls on output backpressure.
module jpeg_bitpack #(
    parameter int MAXW = jpeg_enc_pkg::MAXW,
    parameter int ACCW = jpeg_enc_pkg::ACCW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [MAXW-1:0] CodeData,
    input  logic [5:0]      CodeWidth,
    input  logic            CodeEnable,
    output logic            CodeReady,
    input  logic            Flush,
    output logic [31:0]     DataOut,
    output logic            DataOutEnable,
    input  logic            DataOutRead,
    output logic            DataOutLast,
    output logic [2:0]      DataOutBytes,
    output logic            Busy
);
    import jpeg_enc_pkg::*;

    localparam int CW = $clog2(ACCW + 1);

    bp_state_t       state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d, code_bits;
    logic [CW-1:0]   bcnt_q, bcnt_d, sh;
    logic            stuff_q, stuff_d;
    logic            rdy_en_q;
    logic            byte_vld, byte_rdy, take_byte, pad_byte;
    logic [7:0]      byte_dat;
    logic            drain, drain_done, code_xfer, last_rd;

    // rdy_en_q keeps CodeReady low while reset is held.
    assign CodeReady = rdy_en_q & (state_q == ST_RUN) & (bcnt_q <= CW'(ACCW - MAXW));
    assign code_xfer = CodeEnable & CodeReady;
    assign Busy      = (state_q != ST_RUN);
    assign last_rd   = DataOutEnable & DataOutRead & DataOutLast;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            acc_q    <= '0;
            bcnt_q   <= '0;
            stuff_q  <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            bcnt_q   <= bcnt_d;
            stuff_q  <= stuff_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (Flush) state_d = ST_PAD;
            ST_PAD:    if (bcnt_q == '0 && !stuff_q) state_d = ST_MRK_FF;
            ST_MRK_FF: if (byte_rdy) state_d = ST_MRK_D9;
            ST_MRK_D9: if (byte_rdy) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_done) state_d = ST_DONE;
            ST_DONE:   if (last_rd) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Byte slot source: pending stuff byte, then data bits, then the 1-padded tail.
    always_comb begin
        byte_vld  = 1'b0;
        byte_dat  = STUFF_BYTE;
        take_byte = 1'b0;
        pad_byte  = 1'b0;
        drain     = 1'b0;
        sh        = bcnt_q - CW'(8);
        case (state_q)
            ST_RUN, ST_PAD: begin
                if (stuff_q) begin
                    byte_vld = 1'b1;
                end else if (bcnt_q >= CW'(8)) begin
                    byte_vld  = 1'b1;
                    take_byte = 1'b1;
                    byte_dat  = 8'(acc_q >> sh);
                end else if (state_q == ST_PAD && bcnt_q != '0) begin
                    byte_vld = 1'b1;
                    pad_byte = 1'b1;
                    byte_dat = 8'(acc_q << (CW'(8) - bcnt_q)) | (8'hFF >> bcnt_q);
                end
            end
            ST_MRK_FF: begin
                byte_vld = 1'b1;
                byte_dat = MARKER_PREFIX;
            end
            ST_MRK_D9: begin
                byte_vld = 1'b1;
                byte_dat = EOI_CODE;
            end
            ST_DRAIN: drain = 1'b1;
            default: ;
        endcase
    end

    // Valid bits sit right-justified in acc_q[bcnt_q-1:0]; stale bits above are ignored.
    always_comb begin
        acc_d     = acc_q;
        bcnt_d    = bcnt_q;
        stuff_d   = stuff_q;
        code_bits = ACCW'(CodeData) & ((ACCW'(1) << CodeWidth) - ACCW'(1));
        if (byte_vld && byte_rdy) begin
            if (stuff_q)
                stuff_d = 1'b0;
            else if (take_byte || pad_byte)
                stuff_d = (byte_dat == MARKER_PREFIX);
            if (take_byte)
                bcnt_d = bcnt_q - CW'(8);
            if (pad_byte)
                bcnt_d = '0;
        end
        if (code_xfer) begin
            acc_d  = (acc_q << CodeWidth) | code_bits;
            bcnt_d = bcnt_d + CW'(CodeWidth);
        end
        if (state_q == ST_DONE && last_rd) begin
            acc_d   = '0;
            bcnt_d  = '0;
            stuff_d = 1'b0;
        end
    end

    jpeg_bitpack_word u_word (
        .clk          (clk),
        .rst          (rst),
        .byte_vld_i   (byte_vld),
        .byte_dat_i   (byte_dat),
        .byte_rdy_o   (byte_rdy),
        .drain_i      (drain),
        .drain_done_o (drain_done),
        .dout_o       (DataOut),
        .dout_vld_o   (DataOutEnable),
        .dout_last_o  (DataOutLast),
        .dout_bytes_o (DataOutBytes),
        .dout_rd_i    (DataOutRead)
    );

endmodule

// File: tb/tb_jpeg_bitpack.sv
// Directed, table-driven bench for jpeg_bitpack with hand-computed word images.
module tb_jpeg_bitpack;

    logic        clk;
    logic        rst;
    logic [31:0] CodeData;
    logic [5:0]  CodeWidth;
    logic        CodeEnable;
    logic        CodeReady;
    logic        Flush;
    logic [31:0] DataOut;
    logic        DataOutEnable;
    logic        DataOutRead;
    logic        DataOutLast;
    logic [2:0]  DataOutBytes;
    logic        Busy;

    jpeg_bitpack dut (
        .clk           (clk),
        .rst           (rst),
        .CodeData      (CodeData),
        .CodeWidth     (CodeWidth),
        .CodeEnable    (CodeEnable),
        .CodeReady     (CodeReady),
        .Flush         (Flush),
        .DataOut       (DataOut),
        .DataOutEnable (DataOutEnable),
        .DataOutRead   (DataOutRead),
        .DataOutLast   (DataOutLast),
        .DataOutBytes  (DataOutBytes),
        .Busy          (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int               ncodes;
        logic [3:0][31:0] code;
        logic [3:0][5:0]  w;
        logic             flush;
        int               nwords;
        logic [1:0][31:0] word;
        logic [1:0][2:0]  nb;
        logic [1:0]       last;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  b;
        logic        l;
    } out_t;

    localparam int NV = 8;
    vec_t vt[NV];
    out_t oq[$];
    int   ntests = 0;
    int   nfail  = 0;

    // Words are captured where the DUT will see DataOutEnable & DataOutRead at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst && DataOutEnable && DataOutRead)
                oq.push_back('{d: DataOut, b: DataOutBytes, l: DataOutLast});
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int n,
                           input logic [31:0] c0, input logic [5:0] w0,
                           input logic [31:0] c1, input logic [5:0] w1,
                           input logic [31:0] c2, input logic [5:0] w2,
                           input logic [31:0] c3, input logic [5:0] w3,
                           input logic fl, input int nw,
                           input logic [31:0] d0, input logic [2:0] b0, input logic l0,
                           input logic [31:0] d1, input logic [2:0] b1, input logic l1);
        vt[i].ncodes  = n;
        vt[i].code[0] = c0; vt[i].w[0] = w0;
        vt[i].code[1] = c1; vt[i].w[1] = w1;
        vt[i].code[2] = c2; vt[i].w[2] = w2;
        vt[i].code[3] = c3; vt[i].w[3] = w3;
        vt[i].flush   = fl;
        vt[i].nwords  = nw;
        vt[i].word[0] = d0; vt[i].nb[0] = b0; vt[i].last[0] = l0;
        vt[i].word[1] = d1; vt[i].nb[1] = b1; vt[i].last[1] = l1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_code(input logic [31:0] d, input logic [5:0] w);
        int t = 0;
        CodeData   = d;
        CodeWidth  = w;
        CodeEnable = 1'b1;
        #1;
        while (!CodeReady && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) check("code_accept_timeout", 32'(t), 32'd0);
        @(negedge clk);
        CodeEnable = 1'b0;
    endtask

    task automatic pulse_flush();
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (oq.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        check("word_count", 32'(oq.size()), 32'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_DataOut"},       DataOut,               32'd0);
        check({tag, "_DataOutEnable"}, 32'(DataOutEnable),    32'd0);
        check({tag, "_DataOutLast"},   32'(DataOutLast),      32'd0);
        check({tag, "_DataOutBytes"},  32'(DataOutBytes),     32'd0);
        check({tag, "_Busy"},          32'(Busy),             32'd0);
        check({tag, "_CodeReady"},     32'(CodeReady),        32'd0);
    endtask

    initial begin
        logic [7:0]  mbytes[$];
        logic [31:0] w32;
        int          nacc;

        rst = 1'b0; CodeData = '0; CodeWidth = '0; CodeEnable = 1'b0;
        Flush = 1'b0; DataOutRead = 1'b1;

        set_vec(0, 4, 32'hAB, 6'd8, 32'hCD, 6'd8, 32'hEF, 6'd8, 32'h12, 6'd8, 1'b0, 1,
                32'h12EFCDAB, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0);
        set_vec(1, 2, 32'hFF12, 6'd16, 32'h3456, 6'd16, 32'h0, 6'd0, 32'h0, 6'd0, 1'b1, 2,
                32'h341200FF, 3'd4, 1'b0, 32'h00D9FF56, 3'd3, 1'b1);
        set_vec(2, 1, 32'h5, 6'd3, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 1'b1, 1,
                32'h00D9FFBF, 3'd3, 1'b1, 32'h0, 3'd0, 1'b0);
        set_vec(3, 1, 32'hF, 6'd4, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 1'b1, 1,
                32'hD9FF00FF, 3'd4, 1'b1, 32'h0, 3'd0, 1'b0);
        set_vec(4, 2, 32'hDEADBEEF, 6'd32, 32'hFFFF, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 1'b0, 1,
                32'hEFBEADDE, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0);
        set_vec(5, 4, 32'h16, 6'd5, 32'h3, 6'd3, 32'h11, 6'd8, 32'h2233, 6'd16, 1'b0, 1,
                32'h332211B3, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0);
        set_vec(6, 0, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 1'b1, 1,
                32'h0000D9FF, 3'd2, 1'b1, 32'h0, 3'd0, 1'b0);
        set_vec(7, 1, 32'hFFFF, 6'd16, 32'h0, 6'd0, 32'h0, 6'd0, 32'h0, 6'd0, 1'b0, 1,
                32'h00FF00FF, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0);

        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            oq.delete();
            for (int k = 0; k < vt[i].ncodes; k++)
                send_code(vt[i].code[k], vt[i].w[k]);
            if (vt[i].flush) begin
                pulse_flush();
                check($sformatf("v%0d_busy_after_flush", i), 32'(Busy), 32'd1);
                pulse_flush();
            end
            wait_words(vt[i].nwords);
            for (int j = 0; j < vt[i].nwords && j < oq.size(); j++) begin
                check($sformatf("v%0d_w%0d_data", i, j),  oq[j].d,     vt[i].word[j]);
                check($sformatf("v%0d_w%0d_bytes", i, j), 32'(oq[j].b), 32'(vt[i].nb[j]));
                check($sformatf("v%0d_w%0d_last", i, j),  32'(oq[j].l), 32'(vt[i].last[j]));
            end
            check($sformatf("v%0d_busy_idle", i), 32'(Busy), 32'd0);
        end

        // Backpressure: output held, 8-bit codes streamed until the packer fills.
        oq.delete();
        DataOutRead = 1'b0;
        CodeWidth   = 6'd8;
        CodeEnable  = 1'b1;
        nacc = 0;
        for (int c = 0; c < 30; c++) begin
            CodeData = 32'(8'h10 + nacc);
            #1;
            if (CodeReady) nacc++;
            if (c == 20) check("bp_dataout_mid", DataOut, 32'h13121110);
            @(negedge clk);
        end
        CodeEnable = 1'b0;
        check("bp_accepted", 32'(nacc), 32'd13);
        check("bp_codeready_low", 32'(CodeReady), 32'd0);
        check("bp_dataout_held", DataOut, 32'h13121110);
        check("bp_enable_held", 32'(DataOutEnable), 32'd1);
        DataOutRead = 1'b1;
        wait_words(3);
        pulse_flush();
        wait_words(4);
        for (int b = 0; b < nacc; b++) mbytes.push_back(8'(8'h10 + b));
        mbytes.push_back(8'hFF);
        mbytes.push_back(8'hD9);
        for (int j = 0; j < 4 && j < oq.size(); j++) begin
            w32 = '0;
            for (int k = 0; k < 4; k++)
                if (4 * j + k < mbytes.size()) w32[8*k +: 8] = mbytes[4*j+k];
            check($sformatf("bp_w%0d_data", j), oq[j].d, w32);
            check($sformatf("bp_w%0d_last", j), 32'(oq[j].l), (j == 3) ? 32'd1 : 32'd0);
        end

        // Reset with 20 bits sitting in the accumulator.
        send_code(32'hABCDE, 6'd20);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        oq.delete();
        @(negedge clk);
        for (int k = 1; k <= 4; k++) send_code(32'(k), 6'd8);
        wait_words(1);
        if (oq.size() > 0) begin
            check("post_reset_data", oq[0].d, 32'h04030201);
            check("post_reset_bytes", 32'(oq[0].b), 32'd4);
            check("post_reset_last", 32'(oq[0].l), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
